// File: rtl/clock_time_pkg.sv
// Shared definitions for the BCD time-of-day counter: register map, CTRL
// bit positions, field limits, the packed time payload and BCD validation.
package clock_time_pkg;

   localparam logic [1:0] ADDR_TIME  = 2'd0;
   localparam logic [1:0] ADDR_ALARM = 2'd1;
   localparam logic [1:0] ADDR_CTRL  = 2'd2;

   localparam int unsigned CTRL_ALARM_EN_BIT   = 0;
   localparam int unsigned CTRL_ALARM_PEND_BIT = 1;

   localparam logic [7:0] SS_MAX = 8'h59;
   localparam logic [7:0] MM_MAX = 8'h59;
   localparam logic [7:0] HH_MAX = 8'h23;

   typedef struct packed {
      logic [7:0] hh;
      logic [7:0] mm;
      logic [7:0] ss;
   } time_bcd_t;

   // Both digits must be decimal and the field must not exceed its limit.
   function automatic logic bcd_field_ok(input logic [7:0] v, input logic [7:0] max);
      return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max);
   endfunction

   // A time value is accepted only if every field is valid.
   function automatic logic time_ok(input time_bcd_t t);
      return bcd_field_ok(t.hh, HH_MAX) && bcd_field_ok(t.mm, MM_MAX) &&
             bcd_field_ok(t.ss, SS_MAX);
   endfunction

endpackage

// File: rtl/clock_time_counter_if.sv
// Avalon-MM zero-wait-state register port of the time-of-day counter.
interface clock_time_counter_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport slave  (input  address, chipselect, write_n, writedata, output readdata);
   modport master (output address, chipselect, write_n, writedata, input  readdata);
endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps from MAX to 00; carry flags the wrap.
module bcd_mod_counter
#(
   parameter logic [7:0] MAX = 8'h59
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       inc_i,
   input  logic       load_i,
   input  logic [7:0] load_data_i,
   output logic [7:0] value_o,
   output logic [7:0] next_o,
   output logic       carry_o
);

   logic [7:0] value_q, value_d, inc_val;

   // Next value: load has priority over increment.
   always_comb begin
      inc_val = value_q;
      value_d = value_q;
      if (value_q == MAX) begin
         inc_val = 8'h00;
      end else if (value_q[3:0] == 4'd9) begin
         inc_val = {value_q[7:4] + 4'd1, 4'd0};
      end else begin
         inc_val = {value_q[7:4], value_q[3:0] + 4'd1};
      end
      if (load_i) begin
         value_d = load_data_i;
      end else if (inc_i) begin
         value_d = inc_val;
      end
   end

   // Value register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) value_q <= 8'h00;
      else          value_q <= value_d;
   end

   assign value_o = value_q;
   assign next_o  = value_d;
   assign carry_o = inc_i && (value_q == MAX);

endmodule

// File: rtl/clock_time_counter.sv
// 24 h BCD time-of-day counter with 1 Hz prescaler and Avalon-MM registers.
// Optional alarm (ALARM/CTRL registers, comparator, alarm_irq) is built
// only when CLOCK_TIME_COUNTER_ALARM_EN is defined.
module clock_time_counter
   import clock_time_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 enable_in,
   clock_time_counter_if.slave  avs,
   output logic [23:0]          time_bcd,
   output logic                 tick_1hz,
   output logic                 alarm_irq
);

   localparam int unsigned     PRE_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);

   logic [PRE_W-1:0] pre_q, pre_d;
   logic             wr_en, time_wr, wrap, tick, tick_q;
   logic [7:0]       ss_q, mm_q, hh_q, ss_n, mm_n, hh_n;
   logic             ss_carry, mm_carry, hh_carry_unused;
   time_bcd_t        time_q, time_next, wr_time;
   logic [31:0]      rd_c;
   logic             unused_wdata;

   assign wr_time = time_bcd_t'(avs.writedata[23:0]);
   assign wr_en   = avs.chipselect && !avs.write_n;
   assign time_wr = wr_en && (avs.address == ADDR_TIME) && time_ok(wr_time);
   assign wrap    = enable_in && (pre_q == PRE_LAST);
   // A TIME write on the wrap cycle wins and suppresses the tick.
   assign tick    = wrap && !time_wr;
   assign unused_wdata = ^avs.writedata[31:24];

   // Prescaler next value: cleared by TIME write, holds while paused.
   always_comb begin
      pre_d = pre_q;
      if (time_wr) begin
         pre_d = '0;
      end else if (wrap) begin
         pre_d = '0;
      end else if (enable_in) begin
         pre_d = pre_q + PRE_W'(1);
      end
   end

   // Prescaler and tick pulse registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         tick_q <= tick;
      end
   end

   bcd_mod_counter #(.MAX(SS_MAX)) u_ss (
      .clk(clk), .reset_n(reset_n), .inc_i(tick), .load_i(time_wr),
      .load_data_i(wr_time.ss), .value_o(ss_q), .next_o(ss_n), .carry_o(ss_carry));

   bcd_mod_counter #(.MAX(MM_MAX)) u_mm (
      .clk(clk), .reset_n(reset_n), .inc_i(ss_carry), .load_i(time_wr),
      .load_data_i(wr_time.mm), .value_o(mm_q), .next_o(mm_n), .carry_o(mm_carry));

   bcd_mod_counter #(.MAX(HH_MAX)) u_hh (
      .clk(clk), .reset_n(reset_n), .inc_i(mm_carry), .load_i(time_wr),
      .load_data_i(wr_time.hh), .value_o(hh_q), .next_o(hh_n), .carry_o(hh_carry_unused));

   assign time_q    = '{hh: hh_q, mm: mm_q, ss: ss_q};
   assign time_next = '{hh: hh_n, mm: mm_n, ss: ss_n};
   assign time_bcd  = time_q;
   assign tick_1hz  = tick_q;

`ifdef CLOCK_TIME_COUNTER_ALARM_EN
   time_bcd_t alarm_q, alarm_d;
   logic      alarm_en_q, alarm_en_d, pend_q, pend_d, irq_q;
   logic      alarm_wr, ctrl_wr, alarm_hit;

   assign alarm_wr  = wr_en && (avs.address == ADDR_ALARM) && time_ok(wr_time);
   assign ctrl_wr   = wr_en && (avs.address == ADDR_CTRL);
   // Compare against the value the time register is about to take on a tick.
   assign alarm_hit = tick && alarm_en_q && (time_next == alarm_q);

   // Alarm register updates; a set beats a same-cycle W1C clear.
   always_comb begin
      alarm_d    = alarm_q;
      alarm_en_d = alarm_en_q;
      pend_d     = pend_q;
      if (alarm_wr) begin
         alarm_d = wr_time;
      end
      if (ctrl_wr) begin
         alarm_en_d = avs.writedata[CTRL_ALARM_EN_BIT];
         if (avs.writedata[CTRL_ALARM_PEND_BIT]) pend_d = 1'b0;
      end
      if (alarm_hit) begin
         pend_d = 1'b1;
      end
   end

   // Alarm state and registered interrupt.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         alarm_q    <= '0;
         alarm_en_q <= 1'b0;
         pend_q     <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         alarm_q    <= alarm_d;
         alarm_en_q <= alarm_en_d;
         pend_q     <= pend_d;
         irq_q      <= pend_d && alarm_en_d;
      end
   end

   assign alarm_irq = irq_q;
`else
   logic unused_next;
   assign unused_next = ^time_next;
   assign alarm_irq   = 1'b0;
`endif

   // Zero-latency read mux.
   always_comb begin
      rd_c = 32'h0;
      case (avs.address)
         ADDR_TIME:  rd_c = {8'h00, time_q};
`ifdef CLOCK_TIME_COUNTER_ALARM_EN
         ADDR_ALARM: rd_c = {8'h00, alarm_q};
         ADDR_CTRL: begin
            rd_c[CTRL_ALARM_EN_BIT]   = alarm_en_q;
            rd_c[CTRL_ALARM_PEND_BIT] = pend_q;
         end
`endif
         default:    rd_c = 32'h0;
      endcase
   end

   assign avs.readdata = rd_c;

endmodule

// File: tb/tb_clock_time_counter.sv
// Self-checking bench for clock_time_counter (CLK_HZ = 4). Alarm checks are
// compiled when CLOCK_TIME_COUNTER_ALARM_EN is defined.
module tb_clock_time_counter;

   localparam int unsigned CLK_HZ = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable_in = 1'b0;
   logic [23:0] time_bcd;
   logic        tick_1hz;
   logic        alarm_irq;
   int          n_checks = 0;
   int          n_pass = 0;

   clock_time_counter_if bus();

   clock_time_counter #(.CLK_HZ(CLK_HZ)) dut (
      .clk(clk), .reset_n(reset_n), .enable_in(enable_in), .avs(bus.slave),
      .time_bcd(time_bcd), .tick_1hz(tick_1hz), .alarm_irq(alarm_irq));

   always #5 clk = ~clk;

   // Reference model: time as seconds of day, prescaler as a plain count.
   int m_secs, m_pre;
   bit m_tick, m_irq;
`ifdef CLOCK_TIME_COUNTER_ALARM_EN
   int m_alarm;
   bit m_en, m_pend;
`endif

   function automatic logic [7:0] dec2bcd(int v);
      return 8'((v / 10) * 16 + (v % 10));
   endfunction

   function automatic logic [23:0] to_bcd(int s);
      return {dec2bcd(s / 3600), dec2bcd((s / 60) % 60), dec2bcd(s % 60)};
   endfunction

   function automatic int fld(logic [7:0] f);
      return int'(f[7:4]) * 10 + int'(f[3:0]);
   endfunction

   function automatic int from_bcd(logic [23:0] b);
      return fld(b[23:16]) * 3600 + fld(b[15:8]) * 60 + fld(b[7:0]);
   endfunction

   function automatic bit field_ok(logic [7:0] f, int lim);
      return (int'(f[3:0]) <= 9) && (int'(f[7:4]) <= 9) && (fld(f) <= lim);
   endfunction

   function automatic bit time_ok(logic [23:0] b);
      return field_ok(b[23:16], 23) && field_ok(b[15:8], 59) && field_ok(b[7:0], 59);
   endfunction

   function automatic logic [31:0] model_rd(logic [1:0] a);
      case (a)
         2'd0: return {8'h0, to_bcd(m_secs)};
`ifdef CLOCK_TIME_COUNTER_ALARM_EN
         2'd1: return {8'h0, to_bcd(m_alarm)};
         2'd2: return {30'h0, m_pend, m_en};
`endif
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      m_secs = 0; m_pre = 0; m_tick = 0; m_irq = 0;
`ifdef CLOCK_TIME_COUNTER_ALARM_EN
      m_alarm = 0; m_en = 0; m_pend = 0;
`endif
   endtask

   task automatic model_edge();
      bit wr, hit;
      wr  = bus.chipselect && !bus.write_n;
      hit = 0;
      m_tick = 0;
      if (wr && bus.address == 2'd0 && time_ok(bus.writedata[23:0])) begin
         m_secs = from_bcd(bus.writedata[23:0]);
         m_pre  = 0;
      end else if (enable_in) begin
         if (m_pre == int'(CLK_HZ) - 1) begin
            m_pre  = 0;
            m_secs = (m_secs + 1) % 86400;
            m_tick = 1;
`ifdef CLOCK_TIME_COUNTER_ALARM_EN
            hit = m_en && (m_secs == m_alarm);
`endif
         end else begin
            m_pre++;
         end
      end
`ifdef CLOCK_TIME_COUNTER_ALARM_EN
      if (wr && bus.address == 2'd1 && time_ok(bus.writedata[23:0]))
         m_alarm = from_bcd(bus.writedata[23:0]);
      if (wr && bus.address == 2'd2) begin
         if (bus.writedata[1]) m_pend = 0;
         m_en = bus.writedata[0];
      end
      if (hit) m_pend = 1;
      m_irq = m_pend && m_en;
`else
      m_irq = hit;
`endif
   endtask

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else n_pass++;
   endtask

   // One clock edge: advance the model, then compare every output.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("time_bcd", {8'h0, time_bcd}, {8'h0, to_bcd(m_secs)});
      chk("tick_1hz", 32'(tick_1hz), 32'(m_tick));
      chk("alarm_irq", 32'(alarm_irq), 32'(m_irq));
      chk("readdata", bus.readdata, model_rd(bus.address));
   endtask

   task automatic bus_wr(logic [1:0] a, logic [31:0] d);
      bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
      step();
      bus.chipselect = 1'b0; bus.write_n = 1'b1;
   endtask

   task automatic rd_chk(logic [1:0] a, string nm, logic [31:0] exp);
      bus.address = a;
      #1;
      chk(nm, bus.readdata, exp);
   endtask

   task automatic wait_tick(int max, output int n);
      n = -1;
      for (int i = 1; i <= max && n < 0; i++) begin
         step();
         if (tick_1hz) n = i;
      end
   endtask

   typedef struct {
      logic [1:0]  a;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;

   vec_t tv[10];

   initial begin
      int n;
      logic [1:0]  ra;
      logic [31:0] rd;

      bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'h0;
      enable_in = 1'b1;
      model_reset();

      // Reset state, then first tick after CLK_HZ edges.
      repeat (3) @(negedge clk);
      chk("reset time_bcd", {8'h0, time_bcd}, 32'h0);
      chk("reset tick", 32'(tick_1hz), 32'h0);
      chk("reset irq", 32'(alarm_irq), 32'h0);
      chk("reset readdata", bus.readdata, 32'h0);
      @(negedge clk) reset_n = 1'b1;
      wait_tick(10, n);
      chk("first tick latency", 32'(n), 32'd4);
      chk("first tick time", {8'h0, time_bcd}, 32'h000001);

      // Full wrap 23:59:59 -> 00:00:00.
      bus_wr(2'd0, 32'h00235959);
      wait_tick(10, n);
      chk("wrap latency", 32'(n), 32'd4);
      chk("wrap time", {8'h0, time_bcd}, 32'h000000);

      // Digit carry and rejected write.
      bus_wr(2'd0, 32'h00000009);
      wait_tick(10, n);
      chk("digit carry", {8'h0, time_bcd}, 32'h000010);
      bus_wr(2'd0, 32'h00000060);
      rd_chk(2'd0, "reject 0x60", 32'h00000010);

      // Pause for 10 cycles mid-count delays the tick by 10.
      bus_wr(2'd0, 32'h00000100);
      step(); step();
      enable_in = 1'b0;
      repeat (10) step();
      enable_in = 1'b1;
      wait_tick(20, n);
      chk("paused tick latency", 32'(n + 12), 32'd14);
      chk("paused tick time", {8'h0, time_bcd}, 32'h000101);

      // Register write / readback vectors with counting paused.
      tv[0] = '{2'd0, 32'h00123456, 32'h00123456};
      tv[1] = '{2'd0, 32'h00000060, 32'h00123456};
      tv[2] = '{2'd0, 32'h00240000, 32'h00123456};
      tv[3] = '{2'd0, 32'h000A0000, 32'h00123456};
      tv[4] = '{2'd0, 32'h00005A00, 32'h00123456};
      tv[5] = '{2'd0, 32'hFF235959, 32'h00235959};
      tv[6] = '{2'd3, 32'hFFFFFFFF, 32'h00000000};
`ifdef CLOCK_TIME_COUNTER_ALARM_EN
      tv[7] = '{2'd1, 32'h00000005, 32'h00000005};
      tv[8] = '{2'd1, 32'h00000099, 32'h00000005};
      tv[9] = '{2'd2, 32'hFFFFFFFC, 32'h00000000};
`else
      tv[7] = '{2'd1, 32'h00000005, 32'h00000000};
      tv[8] = '{2'd1, 32'h00000099, 32'h00000000};
      tv[9] = '{2'd2, 32'h00000003, 32'h00000000};
`endif
      enable_in = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bus_wr(tv[i].a, tv[i].d);
         rd_chk(tv[i].a, $sformatf("vector %0d readback", i), tv[i].exp);
      end
      enable_in = 1'b1;

`ifdef CLOCK_TIME_COUNTER_ALARM_EN
      // Alarm set on tick edge, W1C clear, TIME write match, set beats clear.
      bus_wr(2'd1, 32'h00000005);
      bus_wr(2'd2, 32'h00000001);
      bus_wr(2'd0, 32'h00000004);
      wait_tick(10, n);
      chk("alarm tick latency", 32'(n), 32'd4);
      chk("alarm irq on tick", 32'(alarm_irq), 32'h1);
      bus_wr(2'd2, 32'h00000003);
      chk("alarm irq cleared", 32'(alarm_irq), 32'h0);
      bus_wr(2'd0, 32'h00000005);
      step();
      chk("time write match no irq", 32'(alarm_irq), 32'h0);
      bus_wr(2'd0, 32'h00000004);
      repeat (3) step();
      bus_wr(2'd2, 32'h00000003);
      chk("set vs clear tick", 32'(tick_1hz), 32'h1);
      chk("set beats clear", 32'(alarm_irq), 32'h1);
      step();
      chk("irq held", 32'(alarm_irq), 32'h1);
`else
      step();
      chk("irq tied low", 32'(alarm_irq), 32'h0);
`endif

      // TIME write on the wrap cycle wins and restarts the prescaler.
      bus_wr(2'd0, 32'h00000100);
      repeat (3) step();
      bus_wr(2'd0, 32'h00123456);
      chk("wrap write time", {8'h0, time_bcd}, 32'h00123456);
      chk("wrap write no tick", 32'(tick_1hz), 32'h0);
      wait_tick(10, n);
      chk("restart latency", 32'(n), 32'd4);
      chk("restart time", {8'h0, time_bcd}, 32'h00123457);

      // Randomized traffic against the model.
      for (int k = 0; k < 1500; k++) begin
         enable_in = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 5) == 0) begin
            ra = 2'($urandom_range(0, 3));
            case (ra)
               2'd0: case ($urandom_range(0, 3))
                  0:       rd = $urandom;
                  1:       rd = {8'h0, to_bcd(86395 + int'($urandom_range(0, 4)))};
                  default: rd = {8'h0, to_bcd(int'($urandom_range(0, 86399)))};
               endcase
               2'd1:    rd = {8'h0, to_bcd((m_secs + int'($urandom_range(0, 3))) % 86400)};
               2'd2:    rd = 32'($urandom_range(0, 3));
               default: rd = $urandom;
            endcase
            bus_wr(ra, rd);
         end else begin
            bus.address = 2'($urandom_range(0, 3));
            step();
         end
      end

      // Asynchronous reset mid-count.
      enable_in = 1'b1;
      bus.address = 2'd0;
      bus_wr(2'd0, 32'h00115958);
      step(); step();
      #2 reset_n = 1'b0;
      #1;
      chk("async reset time", {8'h0, time_bcd}, 32'h0);
      chk("async reset tick", 32'(tick_1hz), 32'h0);
      chk("async reset irq", 32'(alarm_irq), 32'h0);
      chk("async reset readdata", bus.readdata, 32'h0);
      model_reset();
      @(negedge clk) reset_n = 1'b1;
      wait_tick(10, n);
      chk("post reset latency", 32'(n), 32'd4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
